// File: rtl/queue_pkg.sv
// Shared operation encodings and default depth for the byte queue and its host-side driver.
package queue_pkg;

  localparam int unsigned QUEUE_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_CLR  = 2'b11
  } queue_op_e;

endpackage

// File: rtl/queue_driver.sv
// Host front end for the byte queue: arbitrates clear/read/write into registered ops,
// tracks a shadow occupancy count, and returns dequeued bytes. QUEUE_DRV_STATS_EN adds drop_cnt.
module queue_driver
  import queue_pkg::*;
#(
  parameter int unsigned DEPTH  = QUEUE_DEPTH,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic              clr_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              sync_err,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] q_out,
  input  logic              q_empty,
  input  logic              q_full
`ifdef QUEUE_DRV_STATS_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  queue_op_e         op_q, op_d, op_prev_q;
  logic [DATA_W-1:0] q_in_q, q_in_d;
  logic [CW-1:0]     shadow_q, shadow_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;
  logic              sync_err_q, sync_err_d;

  assign wr_ready = !clr_req && !rd_req && (shadow_q < FULL_CNT);

  always_comb begin
    op_d       = OP_IDLE;
    q_in_d     = q_in_q;
    shadow_d   = shadow_q;
    s1_d       = 1'b0;
    s2_d       = s1_q;
    rd_err_d   = 1'b0;
    rd_valid_d = s2_q;
    rd_data_d  = s2_q ? q_out : rd_data_q;
    sync_err_d = sync_err_q;

    if (clr_req) begin
      if (shadow_q != '0) begin
        op_d     = OP_CLR;
        shadow_d = '0;
        s2_d     = 1'b0;  // squash a read issued last cycle; its byte is flushed
      end
    end else if (rd_req) begin
      if (shadow_q != '0) begin
        op_d     = OP_DEQ;
        shadow_d = shadow_q - 1'b1;
        s1_d     = 1'b1;
      end else begin
        rd_err_d = 1'b1;
      end
    end else if (wr_valid && wr_ready) begin
      op_d     = OP_ENQ;
      q_in_d   = wr_data;
      shadow_d = shadow_q + 1'b1;
    end

    // Only trust queue status once two idle cycles have let any issued op land.
    if (op_q == OP_IDLE && op_prev_q == OP_IDLE &&
        ((q_empty != (shadow_q == '0)) || (q_full != (shadow_q == FULL_CNT)))) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_IDLE;
      op_prev_q  <= OP_IDLE;
      q_in_q     <= '0;
      shadow_q   <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      op_prev_q  <= op_q;
      q_in_q     <= q_in_d;
      shadow_q   <= shadow_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign op       = op_q;
  assign q_in     = q_in_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign sync_err = sync_err_q;

`ifdef QUEUE_DRV_STATS_EN
  logic [7:0] drop_q, drop_d;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  always_comb begin
    drop_inc = {1'b0, wr_valid && !wr_ready} + {1'b0, rd_err_d};
    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_queue_driver.sv
// Directed bench for queue_driver with a behavioural 8-entry queue attached to its op interface.
module tb_queue_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       rd_req = 1'b0;
  logic       clr_req = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       sync_err;
  logic [1:0] op;
  logic [7:0] q_in;
  logic [7:0] q_out;
  logic       q_empty, q_full;
  logic       lie = 1'b0;
`ifdef QUEUE_DRV_STATS_EN
  logic [7:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  queue_driver #(.DEPTH(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .clr_req  (clr_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .sync_err (sync_err),
    .op       (op),
    .q_in     (q_in),
    .q_out    (q_out),
    .q_empty  (q_empty),
    .q_full   (q_full)
`ifdef QUEUE_DRV_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // Behavioural queue: acts on op one edge after the driver registers it.
  logic [7:0] mem [8];
  int unsigned qcnt;

  always @(posedge clk) begin
    if (rst) begin
      qcnt  <= 0;
      q_out <= '0;
    end else begin
      case (op)
        2'b01: if (qcnt < 8) begin
          mem[qcnt] <= q_in;
          qcnt      <= qcnt + 1;
        end
        2'b10: if (qcnt > 0) begin
          q_out <= mem[0];
          for (int i = 0; i < 7; i++) mem[i] <= mem[i+1];
          qcnt  <= qcnt - 1;
        end
        2'b11: begin
          qcnt  <= 0;
          q_out <= '0;
        end
        default: ;
      endcase
    end
  end

  assign q_empty = (qcnt == 0) ^ lie;
  assign q_full  = (qcnt == 8);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_op", 32'(op), 32'h0);
    check("rst_q_in", 32'(q_in), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_rd_err", 32'(rd_err), 32'h0);
    check("rst_sync_err", 32'(sync_err), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);

    // Fill with 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'((i + 1) * 8'h11);
      #1;
      check("fill_ready", 32'(wr_ready), 32'h1);
      step();
      check("fill_op", 32'(op), 32'h1);
      check("fill_q_in", 32'(q_in), 32'((i + 1) * 8'h11));
    end
    check("full_not_yet", 32'(q_full), 32'h0);
    wr_data = 8'h99;
    #1;
    check("full_ready_low", 32'(wr_ready), 32'h0);
    step();
    check("full_op_idle", 32'(op), 32'h0);
    check("q_full_high", 32'(q_full), 32'h1);
    wr_valid = 1'b0;
    step(); step(); step();
    check("full_sync", 32'(sync_err), 32'h0);

    // Drain with 8 back-to-back reads
    for (int j = 0; j < 10; j++) begin
      rd_req = (j < 8);
      step();
      check("drain_op", 32'(op), (j < 8) ? 32'h2 : 32'h0);
      check("drain_rd_err", 32'(rd_err), 32'h0);
      if (j >= 2) begin
        check("drain_valid", 32'(rd_valid), 32'h1);
        check("drain_data", 32'(rd_data), 32'((j - 1) * 8'h11));
      end else begin
        check("drain_valid_early", 32'(rd_valid), 32'h0);
      end
    end
    rd_req = 1'b0;
    step();
    check("drain_valid_end", 32'(rd_valid), 32'h0);
    step(); step();
    check("drain_empty", 32'(q_empty), 32'h1);
    check("drain_sync", 32'(sync_err), 32'h0);

    // Read on empty
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("empty_op", 32'(op), 32'h0);
    check("empty_rd_err", 32'(rd_err), 32'h1);
    check("empty_valid", 32'(rd_valid), 32'h0);
    step();
    check("empty_rd_err_once", 32'(rd_err), 32'h0);
    check("empty_valid2", 32'(rd_valid), 32'h0);
    step();
    check("empty_valid3", 32'(rd_valid), 32'h0);

    // Write loses to simultaneous read
    wr_valid = 1'b1; wr_data = 8'h33;
    step();
    wr_valid = 1'b0;
    step(); step();
    wr_valid = 1'b1; wr_data = 8'h5A; rd_req = 1'b1;
    #1;
    check("coll_ready_low", 32'(wr_ready), 32'h0);
    step();
    check("coll_op_deq", 32'(op), 32'h2);
    rd_req = 1'b0;
    #1;
    check("coll_ready_high", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0;
    check("coll_op_enq", 32'(op), 32'h1);
    check("coll_q_in", 32'(q_in), 32'h5A);
    step();
    check("coll_valid", 32'(rd_valid), 32'h1);
    check("coll_data", 32'(rd_data), 32'h33);
    step();
    check("coll_valid_end", 32'(rd_valid), 32'h0);
    step(); step();
    check("coll_sync", 32'(sync_err), 32'h0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("flush_op", 32'(op), 32'h3);
    step(); step(); step();

    // Clear right after a read squashes it
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 1);
      step();
    end
    wr_valid = 1'b0;
    step(); step();
    rd_req = 1'b1;
    step();
    check("sq_op_deq", 32'(op), 32'h2);
    rd_req = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("sq_op_clr", 32'(op), 32'h3);
    step();
    check("sq_valid1", 32'(rd_valid), 32'h0);
    step();
    check("sq_valid2", 32'(rd_valid), 32'h0);
    step(); step();
    check("sq_empty", 32'(q_empty), 32'h1);
    check("sq_sync", 32'(sync_err), 32'h0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("sq_shadow_zero", 32'(rd_err), 32'h1);
    step(); step();

    // Status disagreement is sticky until reset
    lie = 1'b1;
    step();
    lie = 1'b0;
    check("sync_set", 32'(sync_err), 32'h1);
    step(); step();
    check("sync_sticky", 32'(sync_err), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("sync_rst", 32'(sync_err), 32'h0);

    // Reset with a read in flight
    wr_valid = 1'b1; wr_data = 8'hA1;
    step();
    wr_data = 8'hA2;
    step();
    wr_valid = 1'b0;
    step(); step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_op", 32'(op), 32'h0);
    check("mid_rst_valid", 32'(rd_valid), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_valid1", 32'(rd_valid), 32'h0);
    step();
    check("post_rst_valid2", 32'(rd_valid), 32'h0);
    step();
    check("post_rst_valid3", 32'(rd_valid), 32'h0);

`ifdef QUEUE_DRV_STATS_EN
    check("drop_rst", 32'(drop_cnt), 32'h0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("drop_rd_err", 32'(drop_cnt), 32'h1);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      step();
    end
    check("drop_after_fill", 32'(drop_cnt), 32'h1);
    for (int i = 0; i < 300; i++) step();
    wr_valid = 1'b0;
    check("drop_sat", 32'(drop_cnt), 32'hFF);
    step();
    check("drop_hold", 32'(drop_cnt), 32'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
